// File: rtl/fpu_result_buffer.sv
// fpu_result_buffer: in-order result buffer with sticky IEEE flags and trap request; FPU_RESBUF_SKID_EN selects depth 2 (registered in_ready) over depth 1
module fpu_result_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] fp_in,
  input  logic        db_in,
  input  logic [4:0]  ieee_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] fp_out,
  output logic        db_out,
  output logic [4:0]  ieee_out,
  input  logic [4:0]  trap_en,
  output logic        trap_req,
  output logic [4:0]  trap_flags,
  input  logic        trap_ack,
  input  logic        clr_sticky,
  output logic [4:0]  sticky
);
  typedef enum logic {RUN, TRAP} state_t;
  state_t      state_q, state_d;
  logic [69:0] head_q, head_d;
  logic [1:0]  count_q, count_d;
  logic [4:0]  sticky_q, sticky_d, trap_flags_q, trap_flags_d;
  logic        push, pop, trap_hit;
  assign out_valid = (count_q != 2'd0) & (state_q == RUN);
  assign {fp_out, db_out, ieee_out} = head_q;
  assign pop = out_valid & out_ready;
  assign push = in_valid & in_ready;
  assign trap_hit = pop & (|(ieee_out & trap_en));
  assign trap_req = state_q == TRAP;
  assign trap_flags = trap_flags_q;
  assign sticky = sticky_q;
`ifdef FPU_RESBUF_SKID_EN
  logic [69:0] tail_q, tail_d;
  assign in_ready = count_q < 2'd2;
  // head takes the input when it would be empty, else advances from the tail on pop
  always_comb begin
    head_d = (push & ((count_q == 2'd0) | (pop & count_q == 2'd1))) ? {fp_in, db_in, ieee_in} :
             (pop & count_q == 2'd2) ? tail_q : head_q;
    tail_d = (push & !pop & count_q == 2'd1) ? {fp_in, db_in, ieee_in} : tail_q;
  end
  // second slot storage
  always_ff @(posedge clk) begin
    if (rst) tail_q <= '0;
    else tail_q <= tail_d;
  end
`else
  assign in_ready = (count_q == 2'd0) | pop;
  // single slot refills whenever an accept happens
  always_comb begin
    head_d = push ? {fp_in, db_in, ieee_in} : head_q;
  end
`endif
  // occupancy, trap FSM and sticky flag next-state
  always_comb begin
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    state_d = trap_hit ? TRAP : (state_q == TRAP & trap_ack) ? RUN : state_q;
    trap_flags_d = trap_hit ? (ieee_out & trap_en) : trap_flags_q;
    sticky_d = (clr_sticky ? 5'd0 : sticky_q) | (pop ? ieee_out : 5'd0);
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      head_q <= '0;
      count_q <= '0;
      sticky_q <= '0;
      trap_flags_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      count_q <= count_d;
      sticky_q <= sticky_d;
      trap_flags_q <= trap_flags_d;
    end
  end
endmodule

// File: doc/fpu_result_buffer.md
# fpu_result_buffer

Output stage directly downstream of the special-case rounder. Registers each packed 64-bit result and its 5-bit IEEE exception vector into an in-order buffer and presents it to writeback over a valid/ready handshake. Accumulates sticky IEEE status flags on every delivered result. Raises a held trap request when a delivered result carries an enabled exception.

## Interface
Parameters:
- none; depth is fixed by the configuration macro (2 with skid, 1 without).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  rounder result valid.
- `in_ready`  out  1  buffer can accept this cycle.
- `fp_in`  in  64  packed result (double, or single replicated in both halves).
- `db_in`  in  1  1 = double precision.
- `ieee_in`  in  5  exception vector: [4] INV, [3] DBZ, [2] OVF, [1] UNF, [0] INX.
- `out_valid`  out  1  head entry presented.
- `out_ready`  in  1  writeback accepts.
- `fp_out`  out  64  head result, bit-identical to `fp_in`.
- `db_out`  out  1  head precision.
- `ieee_out`  out  5  head exception vector.
- `trap_en`  in  5  per-flag trap enables, same bit order as `ieee_in`.
- `trap_req`  out  1  trap pending.
- `trap_flags`  out  5  `ieee & trap_en` of the trapping result.
- `trap_ack`  in  1  acknowledge; honoured only while trap pending.
- `clr_sticky`  in  1  clear sticky flags.
- `sticky`  out  5  accumulated flags.

## Operation
- Accept: `in_valid & in_ready`. Entry = {`fp_in`, `db_in`, `ieee_in`}, written at the tail. Data is never modified.
- Deliver: `out_valid & out_ready`. Head is popped. Strict FIFO order.
- `out_valid` = (count != 0) & (state == RUN).
- Accept and deliver in the same cycle: count is unchanged and order is preserved. When count == 1, the new entry becomes the head in the next cycle.
- Sticky update on deliver: `sticky <= (clr_sticky ? 0 : sticky) | ieee_out`.
- Sticky update without deliver: `clr_sticky` sets `sticky` to 0.
- State machine:
  - RUN -> TRAP when a deliver occurs with `|(ieee_out & trap_en)`. In that cycle, `trap_flags <= ieee_out & trap_en`.
  - TRAP -> RUN when `trap_ack` = 1. `trap_flags` holds its value until the next trap.
  - `trap_ack` is ignored in RUN.
- `trap_req` = (state == TRAP).
- In TRAP, `out_valid` = 0. The trapping result has already been delivered; later entries wait. `in_ready` still follows occupancy, so the buffer fills and then back-pressures.
- `trap_en` is sampled at deliver time only. Changing it while in TRAP has no effect on the pending trap.
- Reset values:
  - count 0, `out_valid` 0, state RUN.
  - `trap_req` 0, `trap_flags` 0, `sticky` 0.
  - `fp_out` 0, `db_out` 0, `ieee_out` 0.
  - Reset mid-operation discards all entries and any pending trap.

## Timing
- Latency: an entry accepted at edge N is visible on `out_valid`/`fp_out` in the cycle after edge N.
- Throughput: one result per cycle when `out_ready` is held high and no trap fires.
- `trap_req` rises in the cycle after the trapping deliver and falls in the cycle after `trap_ack`.
- `sticky` reflects a delivered result's flags in the cycle after its deliver.
- Outputs hold their values while `out_valid & !out_ready`.

## Configuration
- `FPU_RESBUF_SKID_EN` defined:
  - Depth 2.
  - `in_ready` = (count < 2). It is a function of registered state only, so there is no combinational path from `out_ready` to `in_ready`.
- `FPU_RESBUF_SKID_EN` undefined:
  - Depth 1.
  - `in_ready` = (count == 0) | (`out_valid & out_ready`), which is a combinational pass-through of `out_ready`.
  - Full throughput is kept, but a timing path runs from writeback to the rounder.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then stream 8 results with `out_ready` = 1 and `trap_en` = 0 -> 8 delivers in order, one per cycle, 1-cycle latency; `sticky` = OR of all `ieee_in`.
- `out_ready` = 0 with continuous `in_valid`:
  - skid build: `in_ready` drops after 2 accepts.
  - non-skid build: `in_ready` drops after 1 accept.
  - Raise `out_ready` -> stored entries drain in order with no loss or duplication.
- `trap_en` = 5'b00100; deliver result with `ieee` 5'b00101, then 2 more queued:
  - `trap_req` = 1 and `trap_flags` = 5'b00100 in the next cycle.
  - `out_valid` stays 0 until `trap_ack`; the queued results follow afterwards.
- `sticky` = 5'b00011, then `clr_sticky` = 1 in the same cycle as delivering `ieee` 5'b10000 -> `sticky` = 5'b10000.
- Assert `rst` while full and in TRAP -> next cycle: count 0, `out_valid` 0, `trap_req` 0, `sticky` 0, `in_ready` 1.
- `trap_ack` pulsed in RUN -> no state change; a later enabled-flag deliver still traps.
